// File: rtl/inst_cache_dm_pkg.sv
// Shared encodings for the direct-mapped instruction cache.
// Holds the memory-bus command/status codes, the fetch status codes seen by
// the IF stage, the cache controller state encoding and TRUE/FALSE.
package inst_cache_dm_pkg;

  // Command driven towards the unified memory controller.
  typedef enum logic [1:0] {
    MEM_NOP  = 2'd0,
    MEM_READ = 2'd1
  } mem_sig_e;

  // Status reported by the unified memory controller.
  typedef enum logic [1:0] {
    MEM_RESTING       = 2'd0,
    MEM_INST_WORKING  = 2'd1,
    MEM_DATA_WORKING  = 2'd2,
    MEM_INST_FINISHED = 2'd3
  } mem_status_e;

  // Status reported to the IF stage.
  typedef enum logic [1:0] {
    IF_FINISHED     = 2'd0,
    I_CACHE_WORKING = 2'd1,
    I_CACHE_STALL   = 2'd2,
    I_CACHE_RESTING = 2'd3
  } if_status_e;

  // Cache controller states.
  typedef enum logic [1:0] {
    ICS_IDLE    = 2'd0,
    ICS_REQ     = 2'd1,
    ICS_WAIT    = 2'd2,
    ICS_RESPOND = 2'd3
  } ics_state_e;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/inst_cache_dm_if.sv
// Bus bundle between the IF stage, the instruction cache and the memory
// controller.
//   Fetch side : inst_addr, inst_fetch_enabled, invalidate (to cache)
//                instruction, inst_fetch_status (from cache)
//   Memory side: mem_data, mem_status (to cache)
//                mem_vis_addr, mem_vis_signal (from cache)
// slave  : the cache's view.
// master : the view of the surrounding IF stage + memory controller.
interface inst_cache_dm_if
  import inst_cache_dm_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32
) ();

  logic [ADDR_WIDTH-1:0] inst_addr;
  logic                  inst_fetch_enabled;
  logic                  invalidate;
  logic [LEN-1:0]        instruction;
  if_status_e            inst_fetch_status;
  logic [LEN-1:0]        mem_data;
  mem_status_e           mem_status;
  logic [ADDR_WIDTH-1:0] mem_vis_addr;
  mem_sig_e              mem_vis_signal;

  modport slave (
    input  inst_addr, inst_fetch_enabled, invalidate, mem_data, mem_status,
    output instruction, inst_fetch_status, mem_vis_addr, mem_vis_signal
  );

  modport master (
    output inst_addr, inst_fetch_enabled, invalidate, mem_data, mem_status,
    input  instruction, inst_fetch_status, mem_vis_addr, mem_vis_signal
  );

endinterface

// File: rtl/inst_cache_dm_line_array.sv
// Valid/tag/data storage of the direct-mapped instruction cache.
// Ports:
//   clk, rst      clock, synchronous active-high reset (valid bits only)
//   index_i       line index shared by reads and writes
//   off_i         word offset within the line for read and word write
//   rd_valid_o    valid bit of the indexed line (combinational)
//   rd_tag_o      tag of the indexed line (combinational)
//   rd_word_o     word at off_i of the indexed line (combinational)
//   tag_we_i      write tag_i into the indexed line and clear its valid bit
//   tag_i         tag to write
//   word_we_i     write word_i at off_i of the indexed line
//   word_i        word to write (already in instruction order)
//   set_valid_i   mark the indexed line valid
//   clr_all_i     clear every valid bit (takes priority)
module inst_cache_dm_line_array #(
  parameter int LEN             = 32,
  parameter int SET_NUM         = 16,
  parameter int SET_INDEX_WIDTH = 4,
  parameter int LINE_WORDS      = 4,
  parameter int OFF_W           = 2,
  parameter int TAG_W           = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SET_INDEX_WIDTH-1:0] index_i,
  input  logic [OFF_W-1:0]           off_i,
  output logic                       rd_valid_o,
  output logic [TAG_W-1:0]           rd_tag_o,
  output logic [LEN-1:0]             rd_word_o,
  input  logic                       tag_we_i,
  input  logic [TAG_W-1:0]           tag_i,
  input  logic                       word_we_i,
  input  logic [LEN-1:0]             word_i,
  input  logic                       set_valid_i,
  input  logic                       clr_all_i
);

  logic [SET_NUM-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [SET_NUM];
  logic [LEN-1:0]     data_q [SET_NUM][LINE_WORDS];

  assign rd_valid_o = valid_q[index_i];
  assign rd_tag_o   = tag_q[index_i];
  assign rd_word_o  = data_q[index_i][off_i];

  // A global clear wins over any per-line update in the same cycle, so an
  // invalidate coinciding with a fill start or completion leaves nothing valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clr_all_i) begin
      valid_q <= '0;
    end else if (tag_we_i) begin
      valid_q[index_i] <= 1'b0;
    end else if (set_valid_i) begin
      valid_q[index_i] <= 1'b1;
    end
  end

  // Tag and data payload carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (tag_we_i) begin
      tag_q[index_i] <= tag_i;
    end
    if (word_we_i) begin
      data_q[index_i][off_i] <= word_i;
    end
  end

endmodule

// File: rtl/inst_cache_dm.sv
// Direct-mapped instruction cache with multi-word lines.
// Hits answer one cycle after the request; misses fill the whole line with
// sequential word reads, stalling while the memory controller serves data
// accesses. Memory words are byte-reversed into instruction order on fill.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   inst_cache_dm_if.slave: fetch request/response and memory bus
module inst_cache_dm
  import inst_cache_dm_pkg::*;
#(
  parameter int ADDR_WIDTH        = 17,
  parameter int LEN               = 32,
  parameter int BYTE_SIZE         = 8,
  parameter int SET_NUM           = 16,
  parameter int SET_INDEX_WIDTH   = 4,
  parameter int LINE_WORDS        = 4,
  parameter int LINE_OFFSET_WIDTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  inst_cache_dm_if.slave  bus
);

  localparam int OFF_W = (LINE_OFFSET_WIDTH > 0) ? LINE_OFFSET_WIDTH : 1;
  localparam int TAG_W = ADDR_WIDTH - SET_INDEX_WIDTH - LINE_OFFSET_WIDTH - 2;
  localparam int NB    = LEN / BYTE_SIZE;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_WORDS * 4 - 1);
  localparam logic [OFF_W-1:0]      LAST_WORD = OFF_W'(LINE_WORDS - 1);

  function automatic logic [SET_INDEX_WIDTH-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
    return SET_INDEX_WIDTH'(a >> (LINE_OFFSET_WIDTH + 2));
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_WIDTH-1:0] a);
    return TAG_W'(a >> (LINE_OFFSET_WIDTH + 2 + SET_INDEX_WIDTH));
  endfunction

  // Single-word lines have no offset field; the 1-bit offset is then tied 0.
  function automatic logic [OFF_W-1:0] off_of(input logic [ADDR_WIDTH-1:0] a);
    if (LINE_WORDS == 1) return '0;
    return OFF_W'(a >> 2);
  endfunction

  // Memory is little-endian; the lowest byte becomes the top byte.
  function automatic logic [LEN-1:0] reorder(input logic [LEN-1:0] w);
    logic [LEN-1:0] r;
    r = '0;
    for (int b = 0; b < NB; b++) begin
      r[(NB-1-b)*BYTE_SIZE +: BYTE_SIZE] = w[b*BYTE_SIZE +: BYTE_SIZE];
    end
    return r;
  endfunction

  ics_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [OFF_W-1:0]      cnt_q, cnt_d;
  logic [LEN-1:0]        instr_q, instr_d;
  if_status_e            status_q, status_d;
  mem_sig_e              msig_q, msig_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic                  pend_q, pend_d;

  logic [SET_INDEX_WIDTH-1:0] arr_index;
  logic [OFF_W-1:0]           arr_off;
  logic                       tag_we, word_we, set_valid, clr_all;
  logic                       rd_valid;
  logic [TAG_W-1:0]           rd_tag;
  logic [LEN-1:0]             rd_word;

  inst_cache_dm_line_array #(
    .LEN             (LEN),
    .SET_NUM         (SET_NUM),
    .SET_INDEX_WIDTH (SET_INDEX_WIDTH),
    .LINE_WORDS      (LINE_WORDS),
    .OFF_W           (OFF_W),
    .TAG_W           (TAG_W)
  ) u_lines (
    .clk         (clk),
    .rst         (rst),
    .index_i     (arr_index),
    .off_i       (arr_off),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_word_o   (rd_word),
    .tag_we_i    (tag_we),
    .tag_i       (tag_of(bus.inst_addr)),
    .word_we_i   (word_we),
    .word_i      (reorder(bus.mem_data)),
    .set_valid_i (set_valid),
    .clr_all_i   (clr_all)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    status_d  = status_q;
    msig_d    = MEM_NOP;
    maddr_d   = maddr_q;
    pend_d    = pend_q;
    tag_we    = FALSE;
    word_we   = FALSE;
    set_valid = FALSE;
    clr_all   = FALSE;
    arr_index = idx_of(addr_q);
    arr_off   = off_of(addr_q);

    unique case (state_q)
      ICS_IDLE: begin
        // The array is looked up with the live request address.
        arr_index = idx_of(bus.inst_addr);
        arr_off   = off_of(bus.inst_addr);
        clr_all   = bus.invalidate;
        if (bus.inst_fetch_enabled) begin
          addr_d = bus.inst_addr;
          // A same-cycle invalidate empties the cache first, forcing a miss.
          if (rd_valid && (rd_tag == tag_of(bus.inst_addr)) && !bus.invalidate) begin
            instr_d  = rd_word;
            status_d = IF_FINISHED;
          end else begin
            status_d = I_CACHE_WORKING;
            cnt_d    = '0;
            tag_we   = TRUE;
            state_d  = ICS_REQ;
          end
        end else begin
          status_d = I_CACHE_RESTING;
        end
      end

      ICS_REQ: begin
        maddr_d = (addr_q & ~LINE_MASK) | (ADDR_WIDTH'(cnt_q) << 2);
        if (bus.invalidate) pend_d = TRUE;
        if (bus.mem_status == MEM_RESTING) begin
          msig_d   = MEM_READ;
          status_d = I_CACHE_WORKING;
          state_d  = ICS_WAIT;
        end else begin
          status_d = I_CACHE_STALL;
        end
      end

      ICS_WAIT: begin
        arr_off = cnt_q;
        if (bus.invalidate) pend_d = TRUE;
        if (bus.mem_status == MEM_INST_FINISHED) begin
          word_we  = TRUE;
          status_d = I_CACHE_WORKING;
          if (cnt_q == LAST_WORD) begin
            state_d = ICS_RESPOND;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ICS_REQ;
          end
        end else if (bus.mem_status == MEM_DATA_WORKING) begin
          status_d = I_CACHE_STALL;
        end else begin
          status_d = I_CACHE_WORKING;
        end
      end

      ICS_RESPOND: begin
        // The filled line is only published if no invalidate arrived during
        // the fill; the requested word is delivered either way.
        instr_d  = rd_word;
        status_d = IF_FINISHED;
        state_d  = ICS_IDLE;
        if (pend_q || bus.invalidate) begin
          clr_all = TRUE;
          pend_d  = FALSE;
        end else begin
          set_valid = TRUE;
        end
      end

      default: state_d = ICS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ICS_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      instr_q  <= '0;
      status_q <= I_CACHE_RESTING;
      msig_q   <= MEM_NOP;
      maddr_q  <= '0;
      pend_q   <= FALSE;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      instr_q  <= instr_d;
      status_q <= status_d;
      msig_q   <= msig_d;
      maddr_q  <= maddr_d;
      pend_q   <= pend_d;
    end
  end

  assign bus.instruction       = instr_q;
  assign bus.inst_fetch_status = status_q;
  assign bus.mem_vis_addr      = maddr_q;
  assign bus.mem_vis_signal    = msig_q;

endmodule

// File: doc/inst_cache_dm.md
Name: inst_cache_dm

Overview:
- Parametrised direct-mapped instruction cache with multi-word lines, replacing the 2-entry fetch buffer between the IF stage and the unified memory controller.
- Serves hits with one-cycle latency.
- On a miss, fills a whole line by issuing sequential word reads, and yields to data accesses by stalling.
- Byte-reverses memory words into instruction order, and supports a full invalidate for fence.i.

Parameters:
- ADDR_WIDTH, 17, byte address width.
- LEN, 32, instruction/word width.
- BYTE_SIZE, 8, byte width used for reordering.
- SET_NUM, 16, number of lines; power of two.
- SET_INDEX_WIDTH, 4, log2(SET_NUM).
- LINE_WORDS, 4, words per line; power of two, at least 1.
- LINE_OFFSET_WIDTH, 2, log2(LINE_WORDS); 0 is legal.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- inst_addr  in  ADDR_WIDTH  fetch byte address; word aligned, bits[1:0] ignored.
- inst_fetch_enabled  in  1  fetch request; sampled only in IDLE.
- invalidate  in  1  one-cycle pulse that clears all valid bits.
- instruction  out  LEN  reordered instruction; valid when status is IF_FINISHED.
- inst_fetch_status  out  2  IF_FINISHED / I_CACHE_WORKING / I_CACHE_STALL / I_CACHE_RESTING.
- mem_data  in  LEN  raw memory word, little-endian byte order.
- mem_status  in  2  MEM_RESTING / MEM_INST_WORKING / MEM_DATA_WORKING / MEM_INST_FINISHED.
- mem_vis_addr  out  ADDR_WIDTH  word read address.
- mem_vis_signal  out  2  MEM_NOP / MEM_READ.

Behaviour:
- Address split:
  - word offset = addr[LINE_OFFSET_WIDTH+1:2]
  - index = next SET_INDEX_WIDTH bits
  - tag = remaining upper bits
- Reorder: instruction = {mem_data[7:0], mem_data[15:8], mem_data[23:16], mem_data[31:24]}, generated over LEN/BYTE_SIZE bytes. Stored already reordered.
- Reset (sync, priority over everything):
  - state IDLE, all valid=0, invalidate_pending=0
  - instruction=0, inst_fetch_status=I_CACHE_RESTING
  - mem_vis_signal=MEM_NOP, mem_vis_addr=0
  - Mid-fill reset abandons the fill; a late MEM_INST_FINISHED is ignored in IDLE.
- States: IDLE, REQ, WAIT, RESPOND.
- IDLE:
  - mem_vis_signal=NOP.
  - If invalidate: clear all valid. An invalidate in the same cycle as a request takes effect first, so the request misses.
  - If inst_fetch_enabled: latch the address.
    - Hit (valid && tag match): instruction<=line word, status<=IF_FINISHED next edge, stay IDLE. Latency is 1 cycle.
    - Miss: status<=I_CACHE_WORKING, fill counter=0, clear valid[index], write tag, go REQ.
  - Otherwise: status<=I_CACHE_RESTING.
  - IF_FINISHED is a one-cycle pulse.
- REQ:
  - mem_vis_addr <= {tag, index, counter, 2'b00}.
  - If mem_status==MEM_RESTING: mem_vis_signal<=MEM_READ, status<=I_CACHE_WORKING, go WAIT.
  - Else (INST_WORKING/DATA_WORKING): mem_vis_signal<=NOP, status<=I_CACHE_STALL, stay REQ. No timeout.
- WAIT:
  - mem_vis_signal<=NOP.
  - On MEM_INST_FINISHED: write the reordered word at counter.
    - If counter==LINE_WORDS-1: go RESPOND.
    - Else: counter+1, go REQ.
  - MEM_DATA_WORKING during WAIT: status<=I_CACHE_STALL, stay WAIT; the read is still owed.
- RESPOND:
  - Set valid[index]=1 unless invalidate_pending.
  - instruction<=requested word, status<=IF_FINISHED, go IDLE.
  - If invalidate_pending: clear all valid and the pending flag in the same edge. The response is still delivered.
- Invalidate outside IDLE sets invalidate_pending.
- inst_fetch_enabled changes outside IDLE are ignored; the latched request completes.
- Miss latency with an idle memory of M-cycle read: about LINE_WORDS*(M+1)+2 cycles.

Decomposition:
- src/defines.v holds:
  - MEM_NOP/MEM_READ
  - MEM_RESTING/MEM_INST_WORKING/MEM_DATA_WORKING/MEM_INST_FINISHED
  - IF_FINISHED/I_CACHE_WORKING/I_CACHE_STALL/I_CACHE_RESTING
  - TRUE/FALSE
  - state encodings ICS_IDLE/ICS_REQ/ICS_WAIT/ICS_RESPOND
- Sub-module i_cache_line_array: valid/tag/data storage.
  - Index-addressed combinational read.
  - Word write and per-line or global valid clear.
- The top level holds the FSM and address logic.

Test Plan:
- Cold miss: memory model with 2-cycle reads, fetch 0x00100, mem word 0x13000000 at 0x100 → four MEM_READs to 0x100/0x104/0x108/0x10C, then IF_FINISHED with instruction=0x00000013.
- Warm hit: after the cold miss, fetch 0x00108 → IF_FINISHED the next cycle, no MEM_READ, instruction equals the reordered word at 0x108.
- Conflict: fetch 0x00100, then 0x00500 (same index with SET_NUM=16, LINE_WORDS=4), then 0x00100 → three full fills, the last one a miss.
- Data contention: hold mem_status=MEM_DATA_WORKING for 5 cycles during REQ → status I_CACHE_STALL, MEM_NOP for 5 cycles, then the read issues and the fill completes correctly.
- Invalidate mid-fill: pulse invalidate in WAIT → the current fetch still returns correct data; a refetch of the same address misses and refills.
- Reset mid-fill: assert rst in WAIT → the next cycle shows status I_CACHE_RESTING and MEM_NOP; a later fetch of the same address misses.
